// File: rtl/dm_store_unit.sv
// dm_store_unit: write-side store aligner for data memory.
// Turns a 32-bit register value plus store type (SW/SH/SB) into a
// lane-aligned, byte-enabled word write held in a one-entry output register
// with valid/ready handshakes on both sides. Counts completed writes
// (saturating) and handles misaligned stores.
// Build option: define DM_STORE_MISALIGN_TRAP_EN to drop misaligned stores
// and report them on misalign_err/bad_addr; otherwise misalignment is ignored.
module dm_store_unit #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [1:0]        st_op,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              misalign_err,
   output logic [ADDR_W-1:0] bad_addr,
   output logic [CNT_W-1:0]  store_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_be;
   logic [CNT_W-1:0]  r_store_cnt;

   logic              w_accept;
   logic              w_drain;
   logic              w_reserved;
   logic              w_write_op;
   logic [31:0]       w_wdata;
   logic [3:0]        w_be;

   assign mem_valid = (r_state == FULL);
   assign st_ready  = ~mem_valid | mem_ready;
   assign w_accept  = st_valid & st_ready;
   assign w_drain   = mem_valid & mem_ready;

   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_be    = r_mem_be;
   assign store_cnt = r_store_cnt;

   // Lane placement: replicate data across lanes and select byte enables
   always_comb begin
      w_wdata    = st_data;
      w_be       = 4'b0000;
      w_reserved = 1'b0;
      case (st_op)
         2'd0: begin
            w_wdata = st_data;
            w_be    = 4'b1111;
         end
         2'd1: begin
            w_wdata = {2{st_data[15:0]}};
            w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'd2: begin
            w_wdata = {4{st_data[7:0]}};
            w_be    = 4'b0001 << st_addr[1:0];
         end
         default: begin
            w_wdata    = 32'h0000_0000;
            w_be       = 4'b0000;
            w_reserved = 1'b1;
         end
      endcase
   end

`ifdef DM_STORE_MISALIGN_TRAP_EN
   logic              w_misaligned;
   logic              r_misalign_err;
   logic [ADDR_W-1:0] r_bad_addr;

   // Misalignment detection: SW needs a word address, SH a halfword address
   always_comb begin
      w_misaligned = 1'b0;
      case (st_op)
         2'd0:    w_misaligned = (st_addr[1:0] != 2'b00);
         2'd1:    w_misaligned = st_addr[0];
         default: w_misaligned = 1'b0;
      endcase
   end

   assign w_write_op = ~w_reserved & ~w_misaligned;

   // Misalign report: one-cycle pulse and sticky capture of the bad address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_misalign_err <= 1'b0;
         r_bad_addr     <= {ADDR_W{1'b0}};
      end else begin
         r_misalign_err <= w_accept & w_misaligned;
         if (w_accept && w_misaligned) begin
            r_bad_addr <= st_addr;
         end
      end
   end

   assign misalign_err = r_misalign_err;
   assign bad_addr     = r_bad_addr;
`else
   assign w_write_op   = ~w_reserved;
   assign misalign_err = 1'b0;
   assign bad_addr     = {ADDR_W{1'b0}};
`endif

   // Output register FSM: load on accept, release on drain, count drains
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= EMPTY;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_wdata <= 32'h0000_0000;
         r_mem_be    <= 4'b0000;
         r_store_cnt <= {CNT_W{1'b0}};
      end else begin
         case (r_state)
            EMPTY, FULL: begin
               if (w_accept && w_write_op) begin
                  r_state     <= FULL;
                  r_mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
                  r_mem_wdata <= w_wdata;
                  r_mem_be    <= w_be;
               end else if (w_drain) begin
                  r_state <= EMPTY;
               end else begin
                  r_state <= r_state;
               end
            end
            default: r_state <= EMPTY;
         endcase
         if (w_drain && (r_store_cnt != {CNT_W{1'b1}})) begin
            r_store_cnt <= r_store_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_dm_store_unit.sv
// Self-checking bench for dm_store_unit: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_dm_store_unit;

`ifdef DM_STORE_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid, st_ready, mem_valid, mem_ready, misalign_err;
   logic [31:0] st_addr, st_data, mem_addr, mem_wdata, bad_addr;
   logic [1:0]  st_op;
   logic [3:0]  mem_be;
   logic [15:0] store_cnt;

   // small-counter instance for saturation
   logic        s4_valid, s4_ready, mv4, mr4, me4;
   logic [31:0] s4_addr, s4_data, ma4, mw4, ba4;
   logic [1:0]  s4_op;
   logic [3:0]  mb4;
   logic [3:0]  cnt4;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_full;
   logic [31:0] m_addr, m_wdata, m_bad;
   logic [3:0]  m_be;
   int          m_cnt;
   bit          m_err;

   always #5 clk = ~clk;

   dm_store_unit #(.ADDR_W(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_op(st_op),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign_err(misalign_err),
      .bad_addr(bad_addr), .store_cnt(store_cnt));

   dm_store_unit #(.ADDR_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .st_valid(s4_valid), .st_ready(s4_ready),
      .st_addr(s4_addr), .st_data(s4_data), .st_op(s4_op),
      .mem_valid(mv4), .mem_ready(mr4), .mem_addr(ma4),
      .mem_wdata(mw4), .mem_be(mb4), .misalign_err(me4),
      .bad_addr(ba4), .store_cnt(cnt4));

   // Expected lane layout: which bytes of the word a store covers
   function automatic void lane_model(input int op, input logic [31:0] a,
                                      input logic [31:0] d,
                                      output logic [3:0] be, output logic [31:0] wd);
      int first;
      int nbytes;
      first = 0;
      nbytes = 0;
      wd = 32'h0;
      if (op == 0) begin
         nbytes = 4; wd = d;
      end else if (op == 1) begin
         first = 2 * int'(a[1]); nbytes = 2;
         wd = {16'h0, d[15:0]} * 32'h0001_0001;
      end else if (op == 2) begin
         first = int'(a[1:0]); nbytes = 1;
         wd = {24'h0, d[7:0]} * 32'h0101_0101;
      end
      be = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (i >= first && i < first + nbytes) be[i] = 1'b1;
      end
   endfunction

   task automatic model_reset();
      m_full = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
      m_cnt = 0; m_err = 1'b0; m_bad = 32'h0;
   endtask

   // Advance one clock: predict from current inputs, then move past the edge
   task automatic step();
      bit acc, drn, mis, wr;
      logic [3:0]  be;
      logic [31:0] wd;
      int a_lo;
      acc  = st_valid && (!m_full || mem_ready);
      drn  = m_full && mem_ready;
      a_lo = int'(st_addr[1:0]);
      mis  = (st_op == 2'd0 && a_lo != 0) || (st_op == 2'd1 && (a_lo % 2) != 0);
      wr   = acc && (st_op != 2'd3) && !(TRAP && mis);
      lane_model(int'(st_op), st_addr, st_data, be, wd);
      @(posedge clk);
      #1;
      if (drn && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_err = TRAP && acc && mis;
      if (m_err) m_bad = st_addr;
      if (wr) begin
         m_full = 1'b1; m_addr = st_addr & 32'hFFFF_FFFC; m_be = be; m_wdata = wd;
      end else if (drn) begin
         m_full = 1'b0;
      end
   endtask

   task automatic drive(input bit v, input int op, input logic [31:0] a,
                        input logic [31:0] d, input bit rdy);
      st_valid = v; st_op = op[1:0]; st_addr = a; st_data = d; mem_ready = rdy;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 0, 32'h0, 32'h0, 1'b0);
      s4_valid = 1'b0; s4_op = 2'd0; s4_addr = 32'h0; s4_data = 32'h0; mr4 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, bad_addr, store_cnt} !== 118'h0) begin
         errors++;
         $display("FAIL reset_state: valid=%b addr=%h wdata=%h be=%b err=%b bad=%h cnt=%0d want all zero",
                  mem_valid, mem_addr, mem_wdata, mem_be, misalign_err, bad_addr, store_cnt);
      end
      reset = 1'b0;
      // pending SW held by back-pressure, then reset mid-FULL
      drive(1'b1, 0, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0);
      step();
      drive(1'b0, 0, 32'h0, 32'h0, 1'b0);
      step();
      checks++;
      if (mem_valid !== 1'b1) begin
         errors++; $display("FAIL reset_prefill: mem_valid=%b want 1", mem_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({mem_valid, mem_addr, mem_wdata, mem_be, store_cnt} !== 85'h0) begin
         errors++;
         $display("FAIL reset_async: valid=%b addr=%h wdata=%h be=%b cnt=%0d want all zero",
                  mem_valid, mem_addr, mem_wdata, mem_be, store_cnt);
      end
      #2 reset = 1'b0;
      model_reset();
      drive(1'b0, 0, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (mem_valid !== 1'b0 || store_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_no_write: valid=%b cnt=%0d want 0 0", mem_valid, store_cnt);
         end
      end
   endtask

   task automatic test_lanes();
      drive(1'b1, 0, 32'h0000_1004, 32'h8888_8888, 1'b1);
      step();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h1004 || mem_be !== 4'b1111 || mem_wdata !== 32'h8888_8888) begin
         errors++;
         $display("FAIL sw_basic: valid=%b addr=%h be=%b wdata=%h want 1 00001004 1111 88888888",
                  mem_valid, mem_addr, mem_be, mem_wdata);
      end
      drive(1'b1, 1, 32'h0000_0012, 32'h1234_ABCD, 1'b1);
      step();
      checks++;
      if (store_cnt !== 16'd1 || mem_addr !== 32'h10 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin
         errors++;
         $display("FAIL sh_basic: cnt=%0d addr=%h be=%b wdata=%h want 1 00000010 1100 abcdabcd",
                  store_cnt, mem_addr, mem_be, mem_wdata);
      end
      drive(1'b1, 2, 32'h0000_0013, 32'h0000_0077, 1'b1);
      step();
      checks++;
      if (mem_addr !== 32'h10 || mem_be !== 4'b1000 || mem_wdata !== 32'h7777_7777) begin
         errors++;
         $display("FAIL sb_basic: addr=%h be=%b wdata=%h want 00000010 1000 77777777",
                  mem_addr, mem_be, mem_wdata);
      end
      drive(1'b0, 0, 32'h0, 32'h0, 1'b1);
      step();
      checks++;
      if (mem_valid !== 1'b0 || store_cnt !== 16'd3) begin
         errors++; $display("FAIL lanes_drain: valid=%b cnt=%0d want 0 3", mem_valid, store_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, w0;
      logic [3:0]  b0;
      int c0;
      drive(1'b1, 0, 32'h0000_0040, 32'h5A5A_0101, 1'b0);
      step();
      a0 = mem_addr; w0 = mem_wdata; b0 = mem_be; c0 = store_cnt;
      drive(1'b1, 2, 32'h0000_0081, 32'h0000_00C3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (st_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready: st_ready=%b want 0", st_ready);
         end
         step();
         checks++;
         if (mem_valid !== 1'b1 || mem_addr !== a0 || mem_wdata !== w0 || mem_be !== b0) begin
            errors++;
            $display("FAIL bp_stable: valid=%b addr=%h wdata=%h be=%b want 1 %h %h %b",
                     mem_valid, mem_addr, mem_wdata, mem_be, a0, w0, b0);
         end
      end
      mem_ready = 1'b1;
      #1;
      checks++;
      if (st_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_ready: st_ready=%b want 1", st_ready);
      end
      step();
      checks++;
      if (mem_valid !== 1'b1 || store_cnt !== 16'(c0 + 1) || mem_addr !== 32'h80 ||
          mem_be !== 4'b0010 || mem_wdata !== 32'hC3C3_C3C3) begin
         errors++;
         $display("FAIL b2b_swap: valid=%b cnt=%0d addr=%h be=%b wdata=%h want 1 %0d 00000080 0010 c3c3c3c3",
                  mem_valid, store_cnt, mem_addr, mem_be, mem_wdata, c0 + 1);
      end
      drive(1'b0, 0, 32'h0, 32'h0, 1'b1);
      step();
   endtask

   task automatic test_misalign();
      drive(1'b1, 0, 32'h0000_0006, 32'h1111_2222, 1'b1);
      step();
      checks++;
      if (TRAP) begin
         if (mem_valid !== 1'b0 || misalign_err !== 1'b1 || bad_addr !== 32'h6) begin
            errors++;
            $display("FAIL misalign_trap: valid=%b err=%b bad=%h want 0 1 00000006",
                     mem_valid, misalign_err, bad_addr);
         end
      end else begin
         if (mem_valid !== 1'b1 || mem_addr !== 32'h4 || mem_be !== 4'b1111 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_ignore: valid=%b addr=%h be=%b err=%b want 1 00000004 1111 0",
                     mem_valid, mem_addr, mem_be, misalign_err);
         end
      end
      drive(1'b0, 0, 32'h0, 32'h0, 1'b1);
      step();
      checks++;
      if (misalign_err !== 1'b0 || bad_addr !== m_bad) begin
         errors++;
         $display("FAIL misalign_pulse: err=%b bad=%h want 0 %h", misalign_err, bad_addr, m_bad);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
               {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_0000),
               $urandom, ($urandom_range(0, 9) < 7));
         #1;
         checks++;
         if (st_ready !== (!m_full || mem_ready)) begin
            errors++; $display("FAIL rand_ready[%0d]: st_ready=%b want %b", i, st_ready, (!m_full || mem_ready));
         end
         step();
         checks++;
         if (mem_valid !== m_full || store_cnt !== 16'(m_cnt) || misalign_err !== m_err || bad_addr !== m_bad) begin
            errors++;
            $display("FAIL rand_ctrl[%0d]: valid=%b cnt=%0d err=%b bad=%h want %b %0d %b %h",
                     i, mem_valid, store_cnt, misalign_err, bad_addr, m_full, m_cnt, m_err, m_bad);
         end
         if (m_full) begin
            checks++;
            if (mem_addr !== m_addr || mem_wdata !== m_wdata || mem_be !== m_be) begin
               errors++;
               $display("FAIL rand_data[%0d]: addr=%h wdata=%h be=%b want %h %h %b",
                        i, mem_addr, mem_wdata, mem_be, m_addr, m_wdata, m_be);
            end
         end
      end
      drive(1'b0, 0, 32'h0, 32'h0, 1'b1);
      step();
   endtask

   task automatic test_saturate();
      s4_valid = 1'b1; s4_op = 2'd3; s4_addr = 32'h100; s4_data = 32'h55; mr4 = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (mv4 !== 1'b0 || cnt4 !== 4'd0) begin
         errors++; $display("FAIL reserved_op: valid=%b cnt=%0d want 0 0", mv4, cnt4);
      end
      s4_op = 2'd2;
      for (int i = 0; i < 17; i++) begin
         s4_data = 32'(i);
         @(posedge clk);
         #1;
      end
      checks++;
      if (cnt4 !== 4'hF || mv4 !== 1'b1) begin
         errors++; $display("FAIL sat_mid: cnt=%0d valid=%b want 15 1", cnt4, mv4);
      end
      s4_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (cnt4 !== 4'hF || mv4 !== 1'b0) begin
         errors++; $display("FAIL sat_final: cnt=%0d valid=%b want 15 0", cnt4, mv4);
      end
   endtask

   initial begin
      test_reset();
      test_lanes();
      test_back_to_back();
      test_misalign();
      test_random();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_store_unit.md
Name: dm_store_unit

Overview:
- Write-side companion to the load/immediate extender: takes a 32-bit register value plus a store type (SW/SH/SB).
- Produces a lane-aligned, byte-enabled word write to data memory.
- Sits between the execute stage and the DM port, behind a one-entry output register with valid/ready handshakes on both sides.
- Counts completed writes and flags misaligned stores.

Parameters:
- ADDR_W, 32, byte-address width.
- CNT_W, 16, width of the completed-store counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- st_valid  input  1  store request valid
- st_ready  output  1  unit can accept a request this cycle
- st_addr  input  ADDR_W  byte address
- st_data  input  32  register value to store
- st_op  input  2  0=SW, 1=SH, 2=SB, 3=reserved
- mem_valid  output  1  write pending toward DM
- mem_ready  input  1  DM accepts the write this cycle
- mem_addr  output  ADDR_W  word-aligned address {st_addr[ADDR_W-1:2],2'b00}
- mem_wdata  output  32  lane-replicated data
- mem_be  output  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- misalign_err  output  1  one-cycle pulse on a dropped misaligned store
- bad_addr  output  ADDR_W  address of the last misaligned store
- store_cnt  output  CNT_W  completed writes, saturating

Behaviour:
- Reset (async, active-high): mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign_err=0, bad_addr=0, store_cnt=0. A pending entry is discarded with no write.
- States:
  - EMPTY (mem_valid=0), FULL (mem_valid=1).
  - st_ready = ~mem_valid | mem_ready, combinational.
- Accept = st_valid & st_ready. Output registers load on that same edge; mem_valid rises the next cycle (latency 1).
- Drain = mem_valid & mem_ready. It completes the write on that edge.
  - Drain without accept: FULL->EMPTY.
  - Accept with valid op: ->FULL.
  - Drain and accept in the same cycle: stays FULL with the new entry, no bubble.
- While FULL and ~mem_ready: mem_addr, mem_wdata, mem_be hold stable; st_ready=0.
- Lane rules:
  - SW: wdata=st_data; be=4'b1111.
  - SH: wdata={2{st_data[15:0]}}; be = st_addr[1] ? 4'b1100 : 4'b0011.
  - SB: wdata={4{st_data[7:0]}}; be = 4'b0001 << st_addr[1:0].
- Reserved op (3): accepted, produces no write. mem_valid goes 0 unless nothing drains (a pending entry stays pending); store_cnt unchanged.
- Misaligned means SW with st_addr[1:0]!=0, or SH with st_addr[0]=1. SB is never misaligned. Handling is per Optional Feature.
- store_cnt increments by 1 on each drain and saturates at all-ones (no wrap).
- misalign_err is registered: high exactly one cycle, the cycle after the offending accept.

Optional Feature:
- Macro: DM_STORE_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned store is accepted but not written; it is treated like a reserved op for state purposes.
  - misalign_err pulses; bad_addr captures st_addr.
  - store_cnt is unchanged.
- Undefined:
  - Misalignment is ignored. SW uses the word address with be=1111. SH selects its half by st_addr[1], ignoring st_addr[0].
  - misalign_err is tied 0 and bad_addr is tied 0.
  - The port list is identical in both builds.

Test Plan:
- Reset mid-FULL (mem_ready=0, pending SW) -> all outputs 0 immediately; no write ever issued after release.
- SW addr=0x0000_1004, data=0x8888_8888, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1004, be=1111, wdata=0x8888_8888; store_cnt=1 after drain.
- SH addr=0x0000_0012, data=0x1234_ABCD -> mem_addr=0x10, be=1100, wdata=0xABCD_ABCD. SB addr=0x13, data=0x0000_0077 -> be=1000, wdata=0x7777_7777.
- Back-pressure: mem_ready=0 for 3 cycles with FULL -> st_ready=0 and outputs stable. Then mem_ready=1 with st_valid=1 -> same-cycle drain+accept, mem_valid stays 1, store_cnt +1.
- SW addr=0x0000_0006 with macro -> no write, misalign_err=1 for one cycle, bad_addr=0x6. Without macro -> write to 0x4 with be=1111, misalign_err=0.
- Reserved op 3, then force CNT_W=4 with 17 drains -> op 3 produces no mem_valid; store_cnt stops at 0xF.
